chord_song_reader: RTL and testbench

- Producer end of the note-loading interface: walks a song ROM and issues load_new_note / note_to_load / duration_to_load to note_distributor.
- Note entries are issued back-to-back, so several notes can start together as a chord. Advance entries hold the sequence for N beats.
- Sits between the song ROM and note_distributor. It shares play and beat with the distributor.

---
 rtl/chord_song_reader.sv | 147 ++++++++++++++
 tb/tb_chord_song_reader.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chord_song_reader.sv
// chord_song_reader: producer side of the note-loading interface.
// Walks one song of the song ROM entry by entry. Note entries are issued to
// note_distributor back-to-back, every 2 cycles, so consecutive notes form a
// chord. Advance entries hold the walk for N beats. An advance with N=0, or
// running off the last entry, ends the song.
//
// Load interface: load_new_note is a one-cycle strobe with no back-pressure.
// note_to_load and duration_to_load are valid in the strobe cycle and hold
// until the next strobe. The consumer must accept a strobe in any cycle, and
// strobes are never closer together than 2 cycles.
module chord_song_reader #(
  parameter int ENTRY_BITS = 5,
  parameter int SONG_BITS  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            play,
  input  logic                            beat,
  input  logic [SONG_BITS-1:0]            song,
  output logic [SONG_BITS+ENTRY_BITS-1:0] rom_addr,
  input  logic [15:0]                     rom_data,
  output logic                            load_new_note,
  output logic [5:0]                      note_to_load,
  output logic [5:0]                      duration_to_load,
  output logic                            song_done
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_ADVANCE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                state_q;
  logic [ENTRY_BITS-1:0] idx_q;
  logic [ENTRY_BITS-1:0] idx_d;
  logic [5:0]            beat_cnt_q;
  logic [5:0]            beat_cnt_d;
  logic [5:0]            adv_n_q;
  logic [SONG_BITS-1:0]  song_q;
  logic                  load_q;
  logic                  done_q;
  logic [5:0]            note_q;
  logic [5:0]            dur_q;

  logic                  is_advance;
  logic                  last_entry;
  logic                  beat_last;
  logic                  song_changed;
  logic                  unused_rom_bits;

  // The ROM address follows the live song input so a song change is
  // presented to the ROM as early as possible.
  assign rom_addr         = {song, idx_q};
  assign load_new_note    = load_q;
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign song_done        = done_q;

  // Bits [14:12] of a note entry carry nothing for this block.
  assign unused_rom_bits  = ^rom_data[14:12];

  // Entry decode and increment helpers used by the walk FSM.
  always_comb begin
    is_advance   = rom_data[15];
    last_entry   = &idx_q;
    idx_d        = idx_q + ENTRY_BITS'(1);
    beat_cnt_d   = beat_cnt_q + 6'd1;
    beat_last    = (beat_cnt_d == adv_n_q);
    song_changed = (song != song_q);
  end

  // Song walk FSM. Reset dominates, then a song change (even while paused),
  // then play gating. Pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      idx_q      <= '0;
      beat_cnt_q <= '0;
      adv_n_q    <= '0;
      song_q     <= song;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      note_q     <= '0;
      dur_q      <= '0;
    end else begin
      load_q <= 1'b0;
      done_q <= 1'b0;
      song_q <= song;
      if (song_changed) begin
        // Restart the new song; a note decoded this cycle is dropped.
        state_q    <= S_FETCH;
        idx_q      <= '0;
        beat_cnt_q <= '0;
      end else if (play) begin
        case (state_q)
          S_FETCH: begin
            state_q <= S_DECODE;
          end
          S_DECODE: begin
            if (!is_advance) begin
              note_q <= rom_data[11:6];
              dur_q  <= rom_data[5:0];
              load_q <= 1'b1;
              if (last_entry) begin
                // Running off the song: final load and song_done coincide.
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_d;
                state_q <= S_FETCH;
              end
            end else if (rom_data[5:0] == 6'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              // A beat in this cycle is deliberately not counted.
              beat_cnt_q <= '0;
              adv_n_q    <= rom_data[5:0];
              state_q    <= S_ADVANCE;
            end
          end
          S_ADVANCE: begin
            if (beat) begin
              beat_cnt_q <= beat_cnt_d;
              if (beat_last) begin
                if (last_entry) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end else begin
                  idx_q   <= idx_d;
                  state_q <= S_FETCH;
                end
              end
            end
          end
          default: begin
            // S_DONE: parked until reset or a song change.
            state_q <= S_DONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chord_song_reader.sv
// Testbench for chord_song_reader: directed timing scenarios driven from
// per-cycle stimulus plans, plus randomized songs checked against a
// transaction-level model of which notes a song should emit.
module tb_chord_song_reader;

  localparam int PMAX = 127;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        beat = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        load_new_note;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        song_done;

  logic [15:0] rom [0:127];

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle stimulus plan and output log, indexed by cycles since reset release.
  bit         beat_plan  [0:PMAX];
  bit         play_plan  [0:PMAX];
  bit         reset_plan [0:PMAX];
  logic [1:0] song_plan  [0:PMAX];
  logic       load_log   [0:PMAX];
  logic [5:0] note_log   [0:PMAX];
  logic [5:0] dur_log    [0:PMAX];
  logic       done_log   [0:PMAX];
  logic [6:0] addr_log   [0:PMAX];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Synchronous song ROM: data follows the address by one clock.
  always @(posedge clk) rom_data <= rom[rom_addr];

  chord_song_reader #(.ENTRY_BITS(5), .SONG_BITS(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .beat             (beat),
    .song             (song),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .load_new_note    (load_new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .song_done        (song_done)
  );

  // ---------------- entry builders ----------------
  function automatic logic [15:0] note_e(input int n, input int d);
    logic [5:0] nn;
    logic [5:0] dd;
    nn = 6'(n);
    dd = 6'(d);
    return {4'b0000, nn, dd};
  endfunction

  function automatic logic [15:0] adv_e(input int n);
    logic [5:0] nn;
    nn = 6'(n);
    return {10'b10_0000_0000, nn};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
  endtask

  task automatic clear_plans(input logic [1:0] s);
    for (int k = 0; k <= PMAX; k++) begin
      beat_plan[k]  = 1'b0;
      play_plan[k]  = 1'b1;
      reset_plan[k] = 1'b0;
      song_plan[k]  = s;
    end
  endtask

  // Reset, then run n cycles following the plans. Cycle k is sampled at the
  // k-th falling edge after reset release, then the plan for k is driven.
  task automatic run_plan(input int n);
    @(negedge clk);
    reset = 1'b1;
    song  = song_plan[0];
    beat  = 1'b0;
    play  = 1'b1;
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      load_log[k] = load_new_note;
      note_log[k] = note_to_load;
      dur_log[k]  = duration_to_load;
      done_log[k] = song_done;
      addr_log[k] = rom_addr;
      reset = reset_plan[k];
      beat  = beat_plan[k];
      play  = play_plan[k];
      song  = song_plan[k];
    end
    beat = 1'b0;
  endtask

  function automatic string load_ks(input int n);
    string s;
    s = "";
    for (int k = 0; k <= n; k++)
      if (load_log[k] === 1'b1) s = (s == "") ? $sformatf("%0d", k) : $sformatf("%s,%0d", s, k);
    return s;
  endfunction

  function automatic string load_vals(input int n);
    string s;
    s = "";
    for (int k = 0; k <= n; k++)
      if (load_log[k] === 1'b1)
        s = (s == "") ? $sformatf("%0d/%0d", note_log[k], dur_log[k])
                      : $sformatf("%s,%0d/%0d", s, note_log[k], dur_log[k]);
    return s;
  endfunction

  function automatic string done_ks(input int n);
    string s;
    s = "";
    for (int k = 0; k <= n; k++)
      if (done_log[k] === 1'b1) s = (s == "") ? $sformatf("%0d", k) : $sformatf("%s,%0d", s, k);
    return s;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_chord();
    string got;
    clear_rom();
    rom[0] = note_e(40, 3);
    rom[1] = note_e(44, 3);
    rom[2] = note_e(47, 3);
    rom[3] = adv_e(0);
    clear_plans(2'd0);
    run_plan(20);
    got = load_ks(20);
    n_checks++;
    if (got != "2,4,6") $display("FAIL chord_load_cycles: got '%s' expected '2,4,6'", got);
    else n_pass++;
    got = load_vals(20);
    n_checks++;
    if (got != "40/3,44/3,47/3") $display("FAIL chord_load_values: got '%s' expected '40/3,44/3,47/3'", got);
    else n_pass++;
    got = done_ks(20);
    n_checks++;
    if (got != "8") $display("FAIL chord_song_done: got '%s' expected '8'", got);
    else n_pass++;
  endtask

  task automatic test_reset();
    // Enters with the DUT parked in DONE holding note 47 / duration 3.
    @(negedge clk);
    reset = 1'b1;
    song  = 2'd3;
    @(negedge clk);
    n_checks++;
    if (load_new_note !== 1'b0) $display("FAIL reset_load: got %0b expected 0", load_new_note);
    else n_pass++;
    n_checks++;
    if (note_to_load !== 6'd0) $display("FAIL reset_note: got %0d expected 0", note_to_load);
    else n_pass++;
    n_checks++;
    if (duration_to_load !== 6'd0) $display("FAIL reset_duration: got %0d expected 0", duration_to_load);
    else n_pass++;
    n_checks++;
    if (song_done !== 1'b0) $display("FAIL reset_song_done: got %0b expected 0", song_done);
    else n_pass++;
    n_checks++;
    if (rom_addr !== 7'd96) $display("FAIL reset_rom_addr: got %0d expected 96", rom_addr);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_advance();
    string got;
    clear_rom();
    rom[0] = note_e(40, 3);
    rom[1] = adv_e(2);
    rom[2] = note_e(50, 5);
    rom[3] = adv_e(0);
    clear_plans(2'd0);
    // Beat every 4 cycles; the one at cycle 3 lands on the DECODE of the advance.
    for (int k = 3; k <= 23; k += 4) beat_plan[k] = 1'b1;
    run_plan(24);
    got = load_ks(24);
    n_checks++;
    if (got != "2,14") $display("FAIL advance_load_cycles: got '%s' expected '2,14'", got);
    else n_pass++;
    got = load_vals(24);
    n_checks++;
    if (got != "40/3,50/5") $display("FAIL advance_load_values: got '%s' expected '40/3,50/5'", got);
    else n_pass++;
    got = done_ks(24);
    n_checks++;
    if (got != "16") $display("FAIL advance_song_done: got '%s' expected '16'", got);
    else n_pass++;
  endtask

  task automatic test_pause();
    string got;
    int    bad;
    clear_rom();
    rom[0] = note_e(40, 3);
    rom[1] = adv_e(3);
    rom[2] = note_e(50, 3);
    rom[3] = adv_e(0);
    clear_plans(2'd0);
    beat_plan[7] = 1'b1;
    for (int k = 8; k <= 27; k++) play_plan[k] = 1'b0;
    for (int k = 9; k <= 27; k += 2) beat_plan[k] = 1'b1;
    beat_plan[31] = 1'b1;
    beat_plan[35] = 1'b1;
    run_plan(48);
    got = load_ks(48);
    n_checks++;
    if (got != "2,38") $display("FAIL pause_load_cycles: got '%s' expected '2,38'", got);
    else n_pass++;
    got = done_ks(48);
    n_checks++;
    if (got != "40") $display("FAIL pause_song_done: got '%s' expected '40'", got);
    else n_pass++;
    bad = 0;
    for (int k = 9; k <= 28; k++) if (addr_log[k] !== 7'd1) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL pause_addr_hold: got %0d cycles off address 1 expected 0", bad);
    else n_pass++;
    got = load_vals(48);
    n_checks++;
    if (got != "40/3,50/3") $display("FAIL pause_load_values: got '%s' expected '40/3,50/3'", got);
    else n_pass++;
  endtask

  task automatic test_song_change();
    string got;
    clear_rom();
    rom[0]  = note_e(40, 3);
    rom[1]  = adv_e(5);
    rom[32] = note_e(33, 7);
    rom[33] = adv_e(4);
    clear_plans(2'd0);
    for (int k = 6; k <= PMAX; k++) song_plan[k] = 2'd1;
    run_plan(20);
    n_checks++;
    if (addr_log[7] !== 7'd32) $display("FAIL change_rom_addr: got %0d expected 32", addr_log[7]);
    else n_pass++;
    got = load_ks(20);
    n_checks++;
    if (got != "2,9") $display("FAIL change_load_cycles: got '%s' expected '2,9'", got);
    else n_pass++;
    got = load_vals(20);
    n_checks++;
    if (got != "40/3,33/7") $display("FAIL change_load_values: got '%s' expected '40/3,33/7'", got);
    else n_pass++;
    got = done_ks(20);
    n_checks++;
    if (got != "") $display("FAIL change_song_done: got '%s' expected none", got);
    else n_pass++;
  endtask

  task automatic test_wrap();
    string got;
    string exp_k;
    string exp_v;
    clear_rom();
    exp_k = "";
    exp_v = "";
    for (int i = 0; i < 32; i++) begin
      rom[64 + i] = note_e(i + 10, (i % 8) + 1);
      exp_k = (i == 0) ? $sformatf("%0d", 2 * i + 2) : $sformatf("%s,%0d", exp_k, 2 * i + 2);
      exp_v = (i == 0) ? $sformatf("%0d/%0d", i + 10, (i % 8) + 1)
                       : $sformatf("%s,%0d/%0d", exp_v, i + 10, (i % 8) + 1);
    end
    clear_plans(2'd2);
    run_plan(72);
    got = load_ks(72);
    n_checks++;
    if (got != exp_k) $display("FAIL wrap_load_cycles: got '%s' expected '%s'", got, exp_k);
    else n_pass++;
    got = load_vals(72);
    n_checks++;
    if (got != exp_v) $display("FAIL wrap_load_values: got '%s' expected '%s'", got, exp_v);
    else n_pass++;
    got = done_ks(72);
    n_checks++;
    if (got != "64") $display("FAIL wrap_song_done: got '%s' expected '64'", got);
    else n_pass++;
    n_checks++;
    if (addr_log[70] !== 7'd95) $display("FAIL wrap_rom_addr: got %0d expected 95", addr_log[70]);
    else n_pass++;
  endtask

  task automatic test_reset_on_load();
    string got;
    clear_rom();
    rom[0] = note_e(40, 3);
    rom[1] = note_e(44, 3);
    rom[2] = note_e(47, 3);
    rom[3] = adv_e(0);
    clear_plans(2'd0);
    reset_plan[2] = 1'b1;
    run_plan(20);
    n_checks++;
    if (load_log[3] !== 1'b0) $display("FAIL rst_load_load: got %0b expected 0", load_log[3]);
    else n_pass++;
    n_checks++;
    if (note_log[3] !== 6'd0) $display("FAIL rst_load_note: got %0d expected 0", note_log[3]);
    else n_pass++;
    n_checks++;
    if (dur_log[3] !== 6'd0) $display("FAIL rst_load_duration: got %0d expected 0", dur_log[3]);
    else n_pass++;
    n_checks++;
    if (done_log[3] !== 1'b0) $display("FAIL rst_load_song_done: got %0b expected 0", done_log[3]);
    else n_pass++;
    n_checks++;
    if (addr_log[3] !== 7'd0) $display("FAIL rst_load_rom_addr: got %0d expected 0", addr_log[3]);
    else n_pass++;
    got = load_ks(20);
    n_checks++;
    if (got != "2,5,7,9") $display("FAIL rst_load_cycles: got '%s' expected '2,5,7,9'", got);
    else n_pass++;
    got = done_ks(20);
    n_checks++;
    if (got != "11") $display("FAIL rst_load_song_done_cycle: got '%s' expected '11'", got);
    else n_pass++;
  endtask

  // Random songs under random play/beat; the scoreboard expects exactly the
  // note entries up to the first end marker (or all 32 entries), in order.
  task automatic test_random_songs();
    logic [11:0] exp_q[$];
    logic [11:0] exp;
    logic [15:0] e;
    logic [1:0]  s;
    int          base;
    int          end_pos;
    int          last_load;
    bit          seen_done;
    bit          quiet;
    for (int it = 0; it < 6; it++) begin
      s       = 2'($urandom_range(0, 3));
      base    = int'(s) * 32;
      end_pos = $urandom_range(1, 40);
      for (int i = 0; i < 32; i++) begin
        if (i == end_pos) rom[base + i] = adv_e(0);
        else if ($urandom_range(0, 3) == 0) rom[base + i] = adv_e($urandom_range(1, 3));
        else rom[base + i] = note_e($urandom_range(0, 63), $urandom_range(0, 63));
      end
      exp_q.delete();
      for (int i = 0; i < 32; i++) begin
        e = rom[base + i];
        if (e[15] && e[5:0] == 6'd0) break;
        if (!e[15]) exp_q.push_back(e[11:0]);
      end
      @(negedge clk);
      reset = 1'b1;
      song  = s;
      play  = 1'b1;
      beat  = 1'b0;
      @(negedge clk);
      reset     = 1'b0;
      last_load = -10;
      seen_done = 1'b0;
      for (int cyc = 1; cyc <= 3000 && !seen_done; cyc++) begin
        @(negedge clk);
        if (load_new_note === 1'b1) begin
          n_checks++;
          if (cyc - last_load < 2) $display("FAIL rand_load_spacing: got %0d cycles expected >=2", cyc - last_load);
          else n_pass++;
          last_load = cyc;
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL rand_extra_load: got %0d/%0d expected no load", note_to_load, duration_to_load);
          end else begin
            exp = exp_q.pop_front();
            if ({note_to_load, duration_to_load} !== exp)
              $display("FAIL rand_load_value: got %0d/%0d expected %0d/%0d",
                       note_to_load, duration_to_load, exp[11:6], exp[5:0]);
            else n_pass++;
          end
        end
        if (song_done === 1'b1) seen_done = 1'b1;
        play = ($urandom_range(0, 4) != 0);
        beat = ($urandom_range(0, 2) == 0);
      end
      n_checks++;
      if (!seen_done) $display("FAIL rand_song_done_timeout: got no song_done expected one within 3000 cycles");
      else n_pass++;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL rand_missing_loads: got %0d left expected 0", exp_q.size());
      else n_pass++;
      quiet = 1'b1;
      repeat (8) begin
        @(negedge clk);
        if (load_new_note !== 1'b0 || song_done !== 1'b0) quiet = 1'b0;
        beat = ($urandom_range(0, 1) == 0);
      end
      n_checks++;
      if (!quiet) $display("FAIL rand_silence_after_done: got activity expected none");
      else n_pass++;
    end
    beat = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_chord();
    test_reset();
    test_advance();
    test_pause();
    test_song_change();
    test_wrap();
    test_reset_on_load();
    test_random_songs();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
